// File: rtl/partition_worker.sv
// partition_worker: per-vertex partition selection for the graph-partitioning datapath.
//
// For each batch of Q vertices, the block streams each vertex's adjacency row from the dist
// SRAM in SUBB sub-batches of D bits. The matching neighbour-partition labels stream from the
// loc SRAM at the same time. It accumulates neighbour counts for all K partitions, then picks
// the partition with the highest count among those not closed by cap_mask_i. One result per
// vertex is returned on a valid/ready channel.
//
// Ports:
//   clk_i, rst_i         clock; asynchronous active-high reset
//   start_i, batch_idx_i start a batch (sampled in idle only); batch index to process
//   busy_o, done_o       busy outside idle; one-cycle pulse at batch end
//   vid_raddr_o/rdata_i  vid SRAM: one word holds the Q vertex ids of a batch
//   dist_ren_o           read enable shared by the dist and loc SRAMs
//   dist_raddr_o/rdata_i adjacency sub-row {vid, s}; bit j set = neighbour j adjacent
//   loc_raddr_o/rdata_i  partition label of each neighbour in sub-batch s
//   cap_mask_i           bit k set = partition k closed
//   out_*                result channel: vertex index, partition, score, all-masked flag
module partition_worker #(
  parameter int unsigned K        = 16,
  parameter int unsigned D        = 256,
  parameter int unsigned SUBB     = 16,
  parameter int unsigned Q        = 16,
  parameter int unsigned VID_BW   = 12,
  parameter int unsigned BATCH_BW = 8,
  localparam int unsigned LOC_BW  = $clog2(K),
  localparam int unsigned SUBB_BW = $clog2(SUBB),
  localparam int unsigned N       = D * SUBB,
  localparam int unsigned CNT_BW  = $clog2(N + 1),
  localparam int unsigned QIDX_BW = $clog2(Q)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [BATCH_BW-1:0]         batch_idx_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [BATCH_BW-1:0]         vid_raddr_o,
  input  logic [Q*VID_BW-1:0]         vid_rdata_i,
  output logic                        dist_ren_o,
  output logic [VID_BW+SUBB_BW-1:0]   dist_raddr_o,
  input  logic [D-1:0]                dist_rdata_i,
  output logic [SUBB_BW-1:0]          loc_raddr_o,
  input  logic [D*LOC_BW-1:0]         loc_rdata_i,
  input  logic [K-1:0]                cap_mask_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [QIDX_BW-1:0]          out_qidx_o,
  output logic [LOC_BW-1:0]           out_part_o,
  output logic [CNT_BW-1:0]           out_score_o,
  output logic                        out_none_o
);

  typedef enum logic [2:0] {
    StIdle, StVid, StVlat, StAcc, StDrain, StSel, StOut, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BATCH_BW-1:0] batch_q, batch_d;
  logic [VID_BW-1:0]   vid_q [Q];
  logic [VID_BW-1:0]   vid_d [Q];
  logic [QIDX_BW-1:0]  q_q, q_d;
  logic [SUBB_BW-1:0]  s_q, s_d;
  // High in the cycle after an ACC read, i.e. when dist/loc read data is valid.
  logic                acc_v_q;
  logic [CNT_BW-1:0]   cnt_q [K];
  logic [CNT_BW-1:0]   cnt_d [K];
  logic [CNT_BW-1:0]   inc   [K];
  logic [QIDX_BW-1:0]  out_qidx_q, out_qidx_d;
  logic [LOC_BW-1:0]   out_part_q, out_part_d;
  logic [CNT_BW-1:0]   out_score_q, out_score_d;
  logic                out_none_q, out_none_d;

  logic                best_found;
  logic [LOC_BW-1:0]   best_k;
  logic [CNT_BW-1:0]   best_cnt;

  // Per-partition histogram of the adjacent neighbours in the returning sub-batch.
  always_comb begin
    for (int k = 0; k < K; k++) inc[k] = '0;
    for (int j = 0; j < D; j++) begin
      if (dist_rdata_i[j]) begin
        inc[loc_rdata_i[j*LOC_BW +: LOC_BW]] = inc[loc_rdata_i[j*LOC_BW +: LOC_BW]] + CNT_BW'(1);
      end
    end
  end

  // Counters clear on the first ACC cycle of a vertex. No read data is valid in that cycle,
  // so the clear never collides with an accumulation.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StAcc && s_q == '0) begin
      for (int k = 0; k < K; k++) cnt_d[k] = '0;
    end else if (acc_v_q) begin
      for (int k = 0; k < K; k++) cnt_d[k] = cnt_q[k] + inc[k];
    end
  end

  // Argmax over open partitions. The strict compare makes ties resolve to the lowest index.
  // With every partition masked, index and score both stay 0.
  always_comb begin
    best_found = 1'b0;
    best_k     = '0;
    best_cnt   = '0;
    for (int k = 0; k < K; k++) begin
      if (!cap_mask_i[k] && (!best_found || cnt_q[k] > best_cnt)) begin
        best_found = 1'b1;
        best_k     = LOC_BW'(k);
        best_cnt   = cnt_q[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    batch_d      = batch_q;
    vid_d        = vid_q;
    q_d          = q_q;
    s_d          = s_q;
    out_qidx_d   = out_qidx_q;
    out_part_d   = out_part_q;
    out_score_d  = out_score_q;
    out_none_d   = out_none_q;
    dist_ren_o   = 1'b0;
    dist_raddr_o = '0;
    loc_raddr_o  = '0;
    out_valid_o  = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          batch_d = batch_idx_i;
          state_d = StVid;
        end
      end
      StVid: state_d = StVlat;
      StVlat: begin
        for (int i = 0; i < Q; i++) vid_d[i] = vid_rdata_i[i*VID_BW +: VID_BW];
        q_d     = '0;
        s_d     = '0;
        state_d = StAcc;
      end
      StAcc: begin
        dist_ren_o   = 1'b1;
        dist_raddr_o = {vid_q[q_q], s_q};
        loc_raddr_o  = s_q;
        if (s_q == SUBB_BW'(SUBB - 1)) begin
          s_d     = '0;
          state_d = StDrain;
        end else begin
          s_d = s_q + SUBB_BW'(1);
        end
      end
      StDrain: state_d = StSel;
      StSel: begin
        out_qidx_d  = q_q;
        out_part_d  = best_k;
        out_score_d = best_cnt;
        out_none_d  = ~best_found;
        state_d     = StOut;
      end
      StOut: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (q_q == QIDX_BW'(Q - 1)) begin
            state_d = StDone;
          end else begin
            q_d     = q_q + QIDX_BW'(1);
            state_d = StAcc;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      batch_q     <= '0;
      q_q         <= '0;
      s_q         <= '0;
      acc_v_q     <= 1'b0;
      out_qidx_q  <= '0;
      out_part_q  <= '0;
      out_score_q <= '0;
      out_none_q  <= 1'b0;
      for (int i = 0; i < Q; i++) vid_q[i] <= '0;
      for (int k = 0; k < K; k++) cnt_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      batch_q     <= batch_d;
      q_q         <= q_d;
      s_q         <= s_d;
      acc_v_q     <= (state_q == StAcc);
      out_qidx_q  <= out_qidx_d;
      out_part_q  <= out_part_d;
      out_score_q <= out_score_d;
      out_none_q  <= out_none_d;
      vid_q       <= vid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign vid_raddr_o = batch_q;
  assign out_qidx_o  = out_qidx_q;
  assign out_part_o  = out_part_q;
  assign out_score_o = out_score_q;
  assign out_none_o  = out_none_q;

endmodule

// File: doc/partition_worker.md
# partition_worker

Parametrised successor to the first-generation partition worker in the graph-partitioning datapath. For each batch of Q vertices, it streams each vertex's adjacency row from the dist SRAM in SUBB sub-batches of D bits, alongside the matching neighbour-partition labels from the loc SRAM. It accumulates per-partition neighbour counts for all K partitions, then selects the best open partition under a capacity mask. One result per vertex is delivered on a valid/ready output channel with backpressure.

## Interface
- K, 16, number of partitions; LOC_BW = clog2(K)
- D, 256, neighbours per sub-batch (bits per dist word)
- SUBB, 16, sub-batches per vertex; SUBB_BW = clog2(SUBB); N = D*SUBB
- Q, 16, vertices per batch
- VID_BW, 12, vertex-id width
- BATCH_BW, 8, batch-index width
- CNT_BW, clog2(N+1), count/score width
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin batch; sampled only in IDLE
- batch_idx  in  BATCH_BW  batch to process; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- vid_raddr  out  BATCH_BW  vid SRAM address
- vid_rdata  in  Q*VID_BW  vertex q at [q*VID_BW +: VID_BW]
- dist_ren  out  1  dist/loc read enable
- dist_raddr  out  VID_BW+SUBB_BW  {vid, s}
- dist_rdata  in  D  bit j = 1 means neighbour j is adjacent
- loc_raddr  out  SUBB_BW  sub-batch s
- loc_rdata  in  D*LOC_BW  label of neighbour j at [j*LOC_BW +: LOC_BW]
- cap_mask  in  K  bit k = 1 means partition k is closed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_qidx  out  clog2(Q)  vertex index within batch
- out_part  out  LOC_BW  chosen partition
- out_score  out  CNT_BW  neighbour count in out_part
- out_none  out  1  all partitions masked

## Operation
- All SRAM reads have 1-cycle latency: data for the address driven in cycle t is valid in cycle t+1.
- FSM: IDLE -> VID -> VLAT -> ACC -> DRAIN -> SEL -> OUT -> (ACC for next vertex, or DONE after vertex Q-1) -> IDLE.
- **IDLE:** on start, latch batch_idx and go to VID. start is ignored in every other state.
- **VID:** drive vid_raddr = latched batch.
- **VLAT:** capture vid_rdata into Q vid registers; set q = 0.
- **ACC:** lasts SUBB cycles, s = 0..SUBB-1.
  - Drive dist_ren = 1, dist_raddr = {vid[q], s}, loc_raddr = s.
  - Clear cnt[0..K-1] on the first ACC cycle of each vertex.
- **Accumulation:** in each of the SUBB cycles in which data returns (ACC cycles 2..SUBB, then DRAIN), add to every k: cnt[k] += popcount over j of (dist_rdata[j] & (loc[j] == k)).
  - Per-cycle increment is at most D; CNT_BW makes overflow impossible.
- **DRAIN:** dist_ren = 0; final accumulation.
- **SEL:** sample cap_mask and pick the argmax of cnt[k] over unmasked k; ties go to the lowest index.
  - If every partition is masked: out_none = 1, out_part = 0, out_score = 0.
  - Register out_qidx, out_part, out_score, out_none.
- **OUT:** out_valid = 1; hold all out_* stable and issue no reads until out_ready = 1.
  - On acceptance, advance: q++ and go to ACC, or go to DONE if q == Q-1.
- **DONE:** done = 1 for one cycle, then IDLE.
- **Reset values:** rst asserted at any time forces IDLE immediately and clears every output and register to 0, including during ACC or OUT.

## Timing
- Start is sampled in cycle 0; VID in cycle 1, VLAT in cycle 2, first ACC in cycle 3.
- Per vertex: SUBB + 3 cycles when out_ready is held high (SUBB ACC, 1 DRAIN, 1 SEL, 1 OUT).
- done is asserted in cycle 3 + Q*(SUBB+3), which is cycle 307 at default parameters; each out_ready stall cycle delays it by one.
- out_valid rises in the cycle after SEL. A transfer occurs on the clock edge where out_valid & out_ready are both high.
- busy falls in the cycle after DONE.

## Test plan
- **Reset:** assert rst mid-ACC -> all outputs read 0 immediately; FSM in IDLE; a subsequent start runs a full batch normally.
- **Zero adjacency:** all dist_rdata = 0, cap_mask = 0 -> 16 results with out_part = 0, out_score = 0, out_qidx = 0..15; done in cycle 307; dist_raddr sequence {vid[q], 0..15} checked.
- **Full adjacency, striped labels:** dist = all ones, loc[j] = j mod 16 -> every cnt = 256, out_part = 0, score 256. Repeat with cap_mask = 0x0001 -> out_part = 1, score 256.
- **Single partition:** loc all = 5, dist all ones only in s = 3, 7, 9 -> out_part = 5, score 768.
  - cap_mask = 0x0020 -> out_part = 0, score 0, out_none = 0.
  - cap_mask = 0xFFFF -> out_none = 1.
- **Backpressure:** out_ready low for 10 cycles on vertex 4 -> out_* held stable, dist_ren = 0 throughout, done delayed to cycle 317.
- **Start while busy:** pulse start with a different batch_idx during ACC -> ignored; vid_raddr stays the original batch; exactly 16 results are produced.
